// File: rtl/trig_burst_ctrl_pkg.sv
// Shared definitions for the triggered burst controller.
//   CntWDefault : default width of the delay/burst counters and config inputs.
//   state_e     : controller state encoding (3-bit).
package trig_burst_ctrl_pkg;

  localparam int unsigned CntWDefault = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StDelay = 3'd2,
    StBurst = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/trig_edge_sync.sv
// Trigger conditioning: synchronizer chain, polarity XOR and active-edge detect.
//   clock    in  system clock
//   reset    in  asynchronous active-low reset
//   trig_in  in  raw asynchronous trigger
//   pol_load in  latch pol_in as the active polarity and reload the edge history
//   pol_in   in  polarity to latch (0 = rising active, 1 = falling active)
//   edge_det out active edge seen this cycle (combinational from flops)
// An edge is reported when the polarized synchronizer output is high while the
// history flop (last cycle's polarized level) is low. On pol_load the history
// takes the current level under the new polarity, so an already-active level
// does not look like an edge.
module trig_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic trig_in,
  input  logic pol_load,
  input  logic pol_in,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pol_q;
  logic                   hist_q;
  logic                   level;

  assign level    = sync_q[SYNC_STAGES-1] ^ pol_q;
  assign edge_det = level & ~hist_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      pol_q  <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
      if (pol_load) begin
        pol_q  <= pol_in;
        hist_q <= sync_q[SYNC_STAGES-1] ^ pol_in;
      end else begin
        hist_q <= level;
      end
    end
  end

endmodule

// File: rtl/trig_burst_ctrl.sv
// Triggered burst controller for a waveform generator.
//   clock, reset            system clock, asynchronous active-low reset
//   trig_in, pn_sel         raw trigger and its active polarity
//   arm, abort, auto_rearm  control requests
//   delay_cnt, burst_len    config, latched on arm (burst_len 0 = continuous)
//   wave_wrap               generator end-of-period pulse
//   gen_en, gen_rst         generator enable and one-cycle phase reset
//   armed, trig_det, trig_miss, done, burst_cnt  status (all registered)
// Trig_det rises on the (SYNC_STAGES+1)-th rising clock edge counting the one
// that first samples the active trigger level. Gen_rst follows trig_det by
// delay_cnt cycles and gen_en rises one cycle after gen_rst.
module trig_burst_ctrl
  import trig_burst_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             trig_in,
  input  logic             pn_sel,
  input  logic             arm,
  input  logic             abort,
  input  logic             auto_rearm,
  input  logic [CNT_W-1:0] delay_cnt,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             wave_wrap,
  output logic             gen_en,
  output logic             gen_rst,
  output logic             armed,
  output logic             trig_det,
  output logic             trig_miss,
  output logic             done,
  output logic [CNT_W-1:0] burst_cnt
);

  state_e           state_q;
  logic [CNT_W-1:0] delay_q;
  logic [CNT_W-1:0] len_q;
  logic             rearm_q;
  logic [CNT_W-1:0] dcnt_q;
  logic             pol_load;
  logic             edge_det;

  assign pol_load = (state_q == StIdle) && arm && !abort;

  trig_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clock   (clock),
    .reset   (reset),
    .trig_in (trig_in),
    .pol_load(pol_load),
    .pol_in  (pn_sel),
    .edge_det(edge_det)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      delay_q   <= '0;
      len_q     <= '0;
      rearm_q   <= 1'b0;
      dcnt_q    <= '0;
      gen_en    <= 1'b0;
      gen_rst   <= 1'b0;
      armed     <= 1'b0;
      trig_det  <= 1'b0;
      trig_miss <= 1'b0;
      done      <= 1'b0;
      burst_cnt <= '0;
    end else begin
      gen_rst   <= 1'b0;
      trig_det  <= 1'b0;
      trig_miss <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
        gen_en  <= 1'b0;
        armed   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (arm) begin
              delay_q   <= delay_cnt;
              len_q     <= burst_len;
              rearm_q   <= auto_rearm;
              burst_cnt <= '0;
              armed     <= 1'b1;
              state_q   <= StArmed;
            end
          end
          StArmed: begin
            if (edge_det) begin
              trig_det  <= 1'b1;
              armed     <= 1'b0;
              burst_cnt <= '0;
              dcnt_q    <= delay_q;
              gen_rst   <= (delay_q == '0);
              state_q   <= StDelay;
            end
          end
          StDelay: begin
            if (edge_det) trig_miss <= 1'b1;
            // Count reaching zero fires gen_rst; the following cycle starts the burst.
            if (dcnt_q == '0) begin
              gen_en  <= 1'b1;
              state_q <= StBurst;
            end else begin
              dcnt_q  <= dcnt_q - 1'b1;
              gen_rst <= (dcnt_q == CNT_W'(1));
            end
          end
          StBurst: begin
            if (edge_det) trig_miss <= 1'b1;
            if (wave_wrap) begin
              if ((len_q != '0) && (burst_cnt == len_q - 1'b1)) begin
                burst_cnt <= len_q;
                gen_en    <= 1'b0;
                done      <= 1'b1;
                state_q   <= StDone;
              end else begin
                burst_cnt <= burst_cnt + 1'b1;
              end
            end
          end
          StDone: begin
            armed   <= rearm_q;
            state_q <= rearm_q ? StArmed : StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
